// File: rtl/priv_plic_types_pkg.sv
// rtl/priv_plic_types_pkg.sv - shared types for the priv PLIC-lite interrupt controller
// Contents: gw_state_t (per-source gateway state), cfg_sel_t (config write target).
package priv_plic_types_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLAIMED = 2'd2
  } gw_state_t;

  typedef enum logic [1:0] {
    SEL_PRIO   = 2'd0,
    SEL_EN     = 2'd1,
    SEL_THRESH = 2'd2,
    SEL_MODE   = 2'd3
  } cfg_sel_t;

endpackage

// File: rtl/priv_plic_gateway.sv
// rtl/priv_plic_gateway.sv - per-source interrupt gateway (IDLE/PENDING/CLAIMED)
// Ports: clk, rst (sync, active-high), src_irq (raw request),
//        edge_mode (only with PLIC_EDGE_TRIG_EN), claim_win (this source won a claim),
//        complete_hit (completion addressed to this source), pending (state is PENDING).
// Optional feature: PLIC_EDGE_TRIG_EN adds the rising-edge detector and 1-deep re-pend latch.
module priv_plic_gateway
  import priv_plic_types_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic src_irq,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic edge_mode,
`endif
  input  logic claim_win,
  input  logic complete_hit,
  output logic pending
);

  gw_state_t state;
  logic      arm;   // request that moves IDLE -> PENDING this edge

`ifdef PLIC_EDGE_TRIG_EN
  logic src_q;
  logic latch;
  logic rise;

  assign rise = src_irq & ~src_q;
  // In edge mode a latched edge from the PENDING/CLAIMED window re-pends on return to IDLE.
  assign arm  = edge_mode ? (rise | latch) : src_irq;
`else
  assign arm  = src_irq;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
`ifdef PLIC_EDGE_TRIG_EN
      src_q <= 1'b0;
      latch <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (arm)          state <= PENDING;
        PENDING: if (claim_win)    state <= CLAIMED;
        CLAIMED: if (complete_hit) state <= IDLE;
        default:                   state <= IDLE;
      endcase
`ifdef PLIC_EDGE_TRIG_EN
      src_q <= src_irq;
      // Only one edge is remembered; later edges while busy are dropped.
      if (state == IDLE && arm)
        latch <= 1'b0;
      else if (edge_mode && rise && state != IDLE)
        latch <= 1'b1;
`endif
    end
  end

  assign pending = (state == PENDING);

endmodule

// File: rtl/priv_plic_lite.sv
// rtl/priv_plic_lite.sv - platform-level interrupt controller feeding the priv block MEIP inputs
// Ports: CLK, RST (sync, active-high); src_irq[NUM_SRC] raw requests (bit i-1 = ID i);
//        cfg_we/cfg_sel/cfg_idx/cfg_wdata config writes; claim_req -> claim_valid/claim_id;
//        complete_req/complete_id; plic_ext_int_m (eligible interrupt), plic_clear_ext_int_m (MEIP clear pulse).
// Optional feature: PLIC_EDGE_TRIG_EN adds per-source level/edge mode registers (cfg_sel 3).
module priv_plic_lite
  import priv_plic_types_pkg::*;
#(
  parameter  int NUM_SRC = 8,
  parameter  int PRIO_W  = 3,
  localparam int ID_W    = $clog2(NUM_SRC + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_sel,
  input  logic [ID_W-1:0]    cfg_idx,
  input  logic [PRIO_W-1:0]  cfg_wdata,
  input  logic               claim_req,
  output logic               claim_valid,
  output logic [ID_W-1:0]    claim_id,
  input  logic               complete_req,
  input  logic [ID_W-1:0]    complete_id,
  output logic               plic_ext_int_m,
  output logic               plic_clear_ext_int_m
);

  logic [PRIO_W-1:0]  prio [NUM_SRC];
  logic [NUM_SRC-1:0] en;
  logic [PRIO_W-1:0]  thresh;
`ifdef PLIC_EDGE_TRIG_EN
  logic [NUM_SRC-1:0] mode;   // 1 = edge-triggered
`endif

  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] claim_win;
  logic [NUM_SRC-1:0] complete_hit;

  logic               best_vld;
  logic [ID_W-1:0]    best_id;
  logic               sel_vld;
  logic [ID_W-1:0]    sel_id;
  logic [PRIO_W-1:0]  sel_prio;

  // Config registers. Out-of-range indices (0 or > NUM_SRC) never match a source slot.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_SRC; i++) prio[i] <= '0;
      en     <= '0;
      thresh <= '0;
`ifdef PLIC_EDGE_TRIG_EN
      mode   <= '0;
`endif
    end else if (cfg_we) begin
      if (cfg_sel_t'(cfg_sel) == SEL_THRESH) thresh <= cfg_wdata;
      for (int i = 0; i < NUM_SRC; i++) begin
        if (cfg_idx == ID_W'(i + 1)) begin
          case (cfg_sel_t'(cfg_sel))
            SEL_PRIO: prio[i] <= cfg_wdata;
            SEL_EN:   en[i]   <= cfg_wdata[0];
`ifdef PLIC_EDGE_TRIG_EN
            SEL_MODE: mode[i] <= cfg_wdata[0];
`endif
            default: ;
          endcase
        end
      end
    end
  end

  // Ascending scan with strict '>' keeps the lowest ID on priority ties.
  // prio > thresh also excludes priority 0 since thresh is never negative.
  always_comb begin
    sel_vld  = 1'b0;
    sel_id   = '0;
    sel_prio = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending[i] && en[i] && prio[i] > thresh && prio[i] > sel_prio) begin
        sel_vld  = 1'b1;
        sel_id   = ID_W'(i + 1);
        sel_prio = prio[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign claim_win[g]    = claim_req & best_vld & (best_id == ID_W'(g + 1));
    assign complete_hit[g] = complete_req & (complete_id == ID_W'(g + 1));

    priv_plic_gateway u_gw (
      .clk          (CLK),
      .rst          (RST),
      .src_irq      (src_irq[g]),
`ifdef PLIC_EDGE_TRIG_EN
      .edge_mode    (mode[g]),
`endif
      .claim_win    (claim_win[g]),
      .complete_hit (complete_hit[g]),
      .pending      (pending[g])
    );
  end

  // Claims consume the registered winner, so a same-cycle config write cannot alter them.
  // best_vld drops at the claim edge so a back-to-back claim sees nothing.
  always_ff @(posedge CLK) begin
    if (RST) begin
      best_vld             <= 1'b0;
      best_id              <= '0;
      claim_valid          <= 1'b0;
      claim_id             <= '0;
      plic_clear_ext_int_m <= 1'b0;
    end else begin
      best_vld             <= sel_vld & ~claim_req;
      best_id              <= sel_id;
      claim_valid          <= claim_req;
      claim_id             <= (claim_req && best_vld) ? best_id : '0;
      plic_clear_ext_int_m <= claim_req & best_vld;
    end
  end

  assign plic_ext_int_m = best_vld;

endmodule

// File: tb/tb_priv_plic_lite.sv
// tb/tb_priv_plic_lite.sv - self-checking bench for priv_plic_lite (table, directed and random)
module tb_priv_plic_lite;

  localparam int N  = 8;
  localparam int PW = 3;
  localparam int IW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  src_irq = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_sel = '0;
  logic [IW-1:0] cfg_idx = '0;
  logic [PW-1:0] cfg_wdata = '0;
  logic          claim_req = 1'b0;
  logic          claim_valid;
  logic [IW-1:0] claim_id;
  logic          complete_req = 1'b0;
  logic [IW-1:0] complete_id = '0;
  logic          plic_ext_int_m;
  logic          plic_clear_ext_int_m;

  always #5 CLK = ~CLK;

  priv_plic_lite #(.NUM_SRC(N), .PRIO_W(PW)) dut (
    .CLK                  (CLK),
    .RST                  (RST),
    .src_irq              (src_irq),
    .cfg_we               (cfg_we),
    .cfg_sel              (cfg_sel),
    .cfg_idx              (cfg_idx),
    .cfg_wdata            (cfg_wdata),
    .claim_req            (claim_req),
    .claim_valid          (claim_valid),
    .claim_id             (claim_id),
    .complete_req         (complete_req),
    .complete_id          (complete_id),
    .plic_ext_int_m       (plic_ext_int_m),
    .plic_clear_ext_int_m (plic_clear_ext_int_m)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: source state 0=idle 1=pending 2=claimed, plus config and output view.
  int m_st   [1:N];
  int m_prio [1:N];
  bit m_en   [1:N];
  bit m_mode [1:N];
  bit m_prev [1:N];
  bit m_lat  [1:N];
  int m_thr;
  bit m_bvld;
  int m_bid;
  bit m_cv;
  int m_cid;
  bit m_clr;

  typedef struct {
    int rst; int src; int we; int sel; int idx; int wd; int clm; int cmp; int cid;
    int e_plic; int e_cv; int e_cid; int e_clr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int rst, int src, int we, int sel, int idx, int wd,
                              int clm, int cmp, int cid,
                              int e_plic, int e_cv, int e_cid, int e_clr);
    vec_t v;
    v.rst = rst; v.src = src; v.we = we; v.sel = sel; v.idx = idx; v.wd = wd;
    v.clm = clm; v.cmp = cmp; v.cid = cid;
    v.e_plic = e_plic; v.e_cv = e_cv; v.e_cid = e_cid; v.e_clr = e_clr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    int win, bp;
    bit go, rise, src;
    if (RST) begin
      for (int i = 1; i <= N; i++) begin
        m_st[i] = 0; m_prio[i] = 0; m_en[i] = 0; m_mode[i] = 0; m_prev[i] = 0; m_lat[i] = 0;
      end
      m_thr = 0; m_bvld = 0; m_bid = 0; m_cv = 0; m_cid = 0; m_clr = 0;
      return;
    end
    // Highest priority above threshold; lowest ID breaks ties.
    win = 0; bp = 0;
    for (int i = 1; i <= N; i++)
      if (m_st[i] == 1 && m_en[i] && m_prio[i] > m_thr && m_prio[i] > bp) begin
        win = i; bp = m_prio[i];
      end
    m_cv  = claim_req;
    m_clr = claim_req && m_bvld;
    m_cid = m_clr ? m_bid : 0;
    for (int i = 1; i <= N; i++) begin
      src  = src_irq[i-1];
      rise = src && !m_prev[i];
      go   = m_mode[i] ? (rise || m_lat[i]) : src;
      if (m_st[i] == 0) begin
        if (go) begin m_st[i] = 1; m_lat[i] = 0; end
      end else begin
        if (m_mode[i] && rise) m_lat[i] = 1;
        if (m_st[i] == 1 && claim_req && m_bvld && m_bid == i) m_st[i] = 2;
        else if (m_st[i] == 2 && complete_req && int'(complete_id) == i) m_st[i] = 0;
      end
      m_prev[i] = src;
    end
    m_bvld = (win != 0) && !claim_req;
    m_bid  = win;
    if (cfg_we) begin
      if (cfg_sel == 2) m_thr = int'(cfg_wdata);
      else if (cfg_idx >= 1 && int'(cfg_idx) <= N) begin
        if (cfg_sel == 0) m_prio[cfg_idx] = int'(cfg_wdata);
        if (cfg_sel == 1) m_en[cfg_idx] = cfg_wdata[0];
`ifdef PLIC_EDGE_TRIG_EN
        if (cfg_sel == 3) m_mode[cfg_idx] = cfg_wdata[0];
`endif
      end
    end
  endfunction

  task automatic drive(input int rst, input int src, input int we, input int sel, input int idx,
                       input int wd, input int clm, input int cmp, input int cid);
    RST          = rst[0];
    src_irq      = N'(src);
    cfg_we       = we[0];
    cfg_sel      = 2'(sel);
    cfg_idx      = IW'(idx);
    cfg_wdata    = PW'(wd);
    claim_req    = clm[0];
    complete_req = cmp[0];
    complete_id  = IW'(cid);
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    check("plic_ext_int_m", 32'(plic_ext_int_m), 32'(m_bvld));
    check("claim_valid", 32'(claim_valid), 32'(m_cv));
    check("claim_id", 32'(claim_id), 32'(m_cid));
    check("plic_clear_ext_int_m", 32'(plic_clear_ext_int_m), 32'(m_clr));
  endtask

  task automatic cyc(input int src, input int clm, input int cmp, input int cid);
    drive(0, src, 0, 0, 0, 0, clm, cmp, cid);
    tick();
  endtask

  task automatic cfgw(input int sel, input int idx, input int wd);
    drive(0, 0, 1, sel, idx, wd, 0, 0, 0);
    tick();
  endtask

  task automatic rst_cyc();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    // Basic single-source flow with hand-derived expectations.
    tbl.push_back(mk(1, 0,    0,0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,    1,0,3,2, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,    1,1,3,1, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,    1,2,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 'h04, 0,0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,    0,0,0,0, 0,0,0, 1,0,0,0));
    tbl.push_back(mk(0, 0,    0,0,0,0, 1,0,0, 0,1,3,1));
    tbl.push_back(mk(0, 0,    0,0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,    0,0,0,0, 0,1,3, 0,0,0,0));
    tbl.push_back(mk(0, 0,    0,0,0,0, 1,0,0, 0,1,0,0));
    tbl.push_back(mk(0, 'h04, 0,0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,    0,0,0,0, 0,0,0, 1,0,0,0));
    tbl.push_back(mk(0, 0,    0,0,0,0, 1,0,0, 0,1,3,1));
    tbl.push_back(mk(0, 'h04, 0,0,0,0, 0,1,3, 0,0,0,0));
    tbl.push_back(mk(0, 'h04, 0,0,0,0, 0,0,0, 0,0,0,0));
    tbl.push_back(mk(0, 0,    0,0,0,0, 0,0,0, 1,0,0,0));
    tbl.push_back(mk(0, 0,    0,0,0,0, 1,0,0, 0,1,3,1));
    tbl.push_back(mk(0, 0,    0,0,0,0, 0,1,3, 0,0,0,0));

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].src, tbl[k].we, tbl[k].sel, tbl[k].idx, tbl[k].wd,
            tbl[k].clm, tbl[k].cmp, tbl[k].cid);
      tick();
      check("tbl_plic", 32'(plic_ext_int_m), 32'(tbl[k].e_plic));
      check("tbl_claim_valid", 32'(claim_valid), 32'(tbl[k].e_cv));
      check("tbl_claim_id", 32'(claim_id), 32'(tbl[k].e_cid));
      check("tbl_clear", 32'(plic_clear_ext_int_m), 32'(tbl[k].e_clr));
    end

    // Priority ties, priority raise, back-to-back claim.
    rst_cyc();
    cfgw(0, 2, 4); cfgw(0, 5, 4); cfgw(1, 2, 1); cfgw(1, 5, 1);
    cyc('h12, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);  check("tie_first", 32'(claim_id), 32'd2);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);  check("tie_second", 32'(claim_id), 32'd5);
    cyc(0, 0, 1, 2); cyc(0, 0, 1, 5);
    cyc('h12, 0, 0, 0);
    cfgw(0, 5, 6);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);  check("raised_prio", 32'(claim_id), 32'd5);
    cyc(0, 1, 0, 0);  check("b2b_id", 32'(claim_id), 32'd0);
                      check("b2b_clear", 32'(plic_clear_ext_int_m), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);  check("third_claim", 32'(claim_id), 32'd2);
    cyc(0, 0, 1, 5); cyc(0, 0, 1, 2);

    // Threshold boundary.
    rst_cyc();
    cfgw(0, 1, 4); cfgw(1, 1, 1); cfgw(2, 0, 4);
    cyc('h01, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    check("thresh_eq_blocks", 32'(plic_ext_int_m), 32'd0);
    cfgw(2, 0, 3);    check("thresh_wr_plus1", 32'(plic_ext_int_m), 32'd0);
    cyc(0, 0, 0, 0);  check("thresh_wr_plus2", 32'(plic_ext_int_m), 32'd1);

    // Completions that must be ignored, then reset during a claim response.
    cyc(0, 0, 1, 0); cyc(0, 0, 1, 9); cyc(0, 0, 1, 1);
    check("bad_complete_keeps", 32'(plic_ext_int_m), 32'd1);
    cyc(0, 1, 0, 0);  check("pending_claim", 32'(claim_id), 32'd1);
    cyc('h01, 0, 1, 1); cyc('h01, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);  check("pre_rst_valid", 32'(claim_valid), 32'd1);
    drive(1, 'h01, 0, 0, 0, 0, 1, 0, 0);
    tick();
    check("rst_plic", 32'(plic_ext_int_m), 32'd0);
    check("rst_valid", 32'(claim_valid), 32'd0);
    check("rst_id", 32'(claim_id), 32'd0);
    check("rst_clear", 32'(plic_clear_ext_int_m), 32'd0);

    // Edge mode: several edges while claimed yield exactly one re-pend.
    rst_cyc();
    cfgw(0, 4, 3); cfgw(1, 4, 1); cfgw(3, 4, 1);
    cyc('h08, 0, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);  check("edge_first", 32'(claim_id), 32'd4);
    for (int r = 0; r < 3; r++) begin
      cyc('h08, 0, 0, 0); cyc(0, 0, 0, 0);
    end
    cyc(0, 0, 1, 4); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
`ifdef PLIC_EDGE_TRIG_EN
    check("edge_repend", 32'(claim_id), 32'd4);
`else
    check("level_no_repend", 32'(claim_id), 32'd0);
`endif
    cyc(0, 0, 1, 4); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);  check("single_repend", 32'(claim_id), 32'd0);

    // Random traffic against the model.
    rst_cyc();
    for (int c = 0; c < 600; c++) begin
      drive(($urandom % 150) == 0 ? 1 : 0,
            int'($urandom & $urandom & $urandom),
            ($urandom % 3) == 0 ? 1 : 0,
            int'($urandom_range(0, 3)),
            int'($urandom_range(0, 10)),
            ($urandom % 4 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 3)),
            ($urandom % 5) == 0 ? 1 : 0,
            ($urandom % 3) == 0 ? 1 : 0,
            int'($urandom_range(0, 9)));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
